// File: rtl/pipelined_carry_adder_pkg.sv
// Shared sizing defaults, operation mode and per-stage control payload for the
// pipelined carry adder.
package pipelined_carry_adder_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SLICE_W = 8;

   typedef enum logic [0:0] {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_mode_t;

   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

   function automatic int calc_stages(input int width, input int slice_w);
      calc_stages = width / slice_w;
   endfunction

endpackage

// File: rtl/pipelined_carry_adder_carry_slice.sv
// SLICE_W-bit combinational ripple slice; also exposes the carry into its MSB
// so the parent can derive signed overflow as msb_ci ^ co.
module pipelined_carry_adder_carry_slice #(
   parameter int SLICE_W = 8
) (
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic               i_ci,
   output logic [SLICE_W-1:0] o_s,
   output logic               o_co,
   output logic               o_msb_ci
);

   // Ripple the carry through every bit of the slice.
   always_comb begin
      logic w_carry;
      w_carry = i_ci;
      o_s     = '0;
      for (int i = 0; i < SLICE_W - 1; i++) begin
         o_s[i]  = i_a[i] ^ i_b[i] ^ w_carry;
         w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
      end
      o_msb_ci       = w_carry;
      o_s[SLICE_W-1] = i_a[SLICE_W-1] ^ i_b[SLICE_W-1] ^ w_carry;
      o_co           = (i_a[SLICE_W-1] & i_b[SLICE_W-1])
                     | (w_carry & (i_a[SLICE_W-1] ^ i_b[SLICE_W-1]));
   end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: one SLICE_W carry slice per stage, carry registered
// between stages, global stall on output backpressure. Optional clamp on
// signed overflow is enabled by defining PIPE_ADDER_SATURATE_EN.
module pipelined_carry_adder
   import pipelined_carry_adder_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SLICE_W = DEF_SLICE_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             cin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int STAGES = calc_stages(WIDTH, SLICE_W);

   op_mode_t                         w_op;
   logic                             w_adv;
   logic [WIDTH-1:0]                 w_b_eff;
   logic                             w_cin0;
   logic [STAGES-1:0][SLICE_W-1:0]   w_sa;
   logic [STAGES-1:0][SLICE_W-1:0]   w_sb;
   logic [STAGES-1:0][SLICE_W-1:0]   w_s;
   logic [STAGES-1:0]                w_sci;
   logic [STAGES-1:0]                w_co;
   logic [STAGES-1:0]                w_msb_ci;
   logic [WIDTH-1:0]                 w_sum_next [STAGES];
   logic [WIDTH-1:0]                 w_out_sum;
   logic                             w_ovf;

   stage_ctl_t                       r_ctl [STAGES];
   logic [WIDTH-1:0]                 r_a   [STAGES];
   logic [WIDTH-1:0]                 r_b   [STAGES];
   logic [WIDTH-1:0]                 r_sum [STAGES];
   logic                             r_ovf;

   assign w_op        = sub_i ? OP_SUB : OP_ADD;
   assign out_valid_o = r_ctl[STAGES-1].valid;
   assign w_adv       = !out_valid_o || out_ready_i;
   assign in_ready_o  = w_adv;
   assign sum_o       = r_sum[STAGES-1];
   assign cout_o      = r_ctl[STAGES-1].carry;
   assign ovf_o       = r_ovf;

   // Subtract is A + ~B + 1; the external carry-in only applies to add.
   always_comb begin
      case (w_op)
         OP_SUB: begin
            w_b_eff = ~b_i;
            w_cin0  = 1'b1;
         end
         OP_ADD: begin
            w_b_eff = b_i;
            w_cin0  = cin_i;
         end
         default: begin
            w_b_eff = b_i;
            w_cin0  = cin_i;
         end
      endcase
   end

   // Stage 0 slices the live operands; later stages slice their delayed tails.
   always_comb begin
      w_sa     = '0;
      w_sb     = '0;
      w_sci    = '0;
      w_sa[0]  = a_i[SLICE_W-1:0];
      w_sb[0]  = w_b_eff[SLICE_W-1:0];
      w_sci[0] = w_cin0;
      for (int k = 1; k < STAGES; k++) begin
         w_sa[k]  = r_a[k-1][k*SLICE_W +: SLICE_W];
         w_sb[k]  = r_b[k-1][k*SLICE_W +: SLICE_W];
         w_sci[k] = r_ctl[k-1].carry;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      pipelined_carry_adder_carry_slice #(
         .SLICE_W (SLICE_W)
      ) u_slice (
         .i_a      (w_sa[k]),
         .i_b      (w_sb[k]),
         .i_ci     (w_sci[k]),
         .o_s      (w_s[k]),
         .o_co     (w_co[k]),
         .o_msb_ci (w_msb_ci[k])
      );
   end

   // Merge each new slice into the partial result carried down the pipe.
   always_comb begin
      w_sum_next[0]                = '0;
      w_sum_next[0][SLICE_W-1:0]   = w_s[0];
      for (int k = 1; k < STAGES; k++) begin
         w_sum_next[k]                        = r_sum[k-1];
         w_sum_next[k][k*SLICE_W +: SLICE_W]  = w_s[k];
      end
      w_ovf = w_msb_ci[STAGES-1] ^ w_co[STAGES-1];
   end

`ifdef PIPE_ADDER_SATURATE_EN
   // On overflow the true result's sign follows A, so clamp towards it.
   always_comb begin
      w_out_sum = w_sum_next[STAGES-1];
      if (w_ovf) begin
         if (w_sa[STAGES-1][SLICE_W-1]) begin
            w_out_sum = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            w_out_sum = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else begin
         w_out_sum = w_sum_next[STAGES-1];
      end
   end
`else
   // Wrapping result straight from the last slice.
   always_comb begin
      w_out_sum = w_sum_next[STAGES-1];
   end
`endif

   // Pipeline registers: all stages advance together or all hold.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < STAGES; k++) begin
            r_ctl[k] <= '0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_ctl[0].valid <= in_valid_i;
         r_ctl[0].carry <= w_co[0];
         r_a[0]         <= a_i;
         r_b[0]         <= w_b_eff;
         for (int k = 1; k < STAGES; k++) begin
            r_ctl[k].valid <= r_ctl[k-1].valid;
            r_ctl[k].carry <= w_co[k];
            r_a[k]         <= r_a[k-1];
            r_b[k]         <= r_b[k-1];
         end
         for (int k = 0; k < STAGES - 1; k++) begin
            r_sum[k] <= w_sum_next[k];
         end
         r_sum[STAGES-1] <= w_out_sum;
         r_ovf           <= w_ovf;
      end
   end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder: arithmetic reference model with
// an in-order scoreboard, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_pipelined_carry_adder;

   localparam int W   = 32;
   localparam int LAT = 4;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         sub_i;
   logic         cin_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [W-1:0] sum_o;
   logic         cout_o;
   logic         ovf_o;

   pipelined_carry_adder u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .sub_i       (sub_i),
      .cin_i       (cin_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .sum_o       (sum_o),
      .cout_o      (cout_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   res_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   n_out  = 0;

`ifdef PIPE_ADDER_SATURATE_EN
   localparam logic [W-1:0] E_OVF_POS = 32'h7FFF_FFFF;
   localparam logic [W-1:0] E_OVF_SUB = 32'h8000_0000;
   localparam logic [W-1:0] E_OVF_NEG = 32'h8000_0000;
`else
   localparam logic [W-1:0] E_OVF_POS = 32'h8000_0000;
   localparam logic [W-1:0] E_OVF_SUB = 32'h7FFF_FFFF;
   localparam logic [W-1:0] E_OVF_NEG = 32'h0000_0000;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain (W+1)-bit arithmetic and the signed-overflow rule.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin);
      logic [W-1:0] bp;
      logic [W:0]   full;
      res_t         r;
      bp     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
`ifdef PIPE_ADDER_SATURATE_EN
      if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      return r;
   endfunction

   // Scoreboard: push on input transfer, pop and compare on output transfer.
   always @(negedge clk_i) begin
      res_t e;
      if (rst_i) begin
         exp_q.delete();
      end else begin
         check("in_ready_rule", {63'd0, in_ready_o}, {63'd0, (!out_valid_o || out_ready_i)});
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_out: got sum 0x%0h, expected no result", sum_o);
            end else begin
               e = exp_q.pop_front();
               n_out++;
               check("sb_sum",  {32'd0, sum_o},  {32'd0, e.sum});
               check("sb_cout", {63'd0, cout_o}, {63'd0, e.cout});
               check("sb_ovf",  {63'd0, ovf_o},  {63'd0, e.ovf});
            end
         end
         if (in_valid_i && in_ready_o) exp_q.push_back(model(a_i, b_i, sub_i, cin_i));
      end
   end

   // Called #1 after a posedge with an idle pipe and out_ready_i high.
   task automatic run_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sub, input logic cin, input logic [W-1:0] es,
                             input logic ec, input logic eo);
      int lat;
      bit seen;
      a_i = a; b_i = b; sub_i = sub; cin_i = cin; in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk_i);
         lat++;
         if (out_valid_o) seen = 1'b1;
      end
      check({name, "_latency"}, 64'(lat), 64'(LAT));
      if (seen) begin
         check({name, "_sum"},  {32'd0, sum_o},  {32'd0, es});
         check({name, "_cout"}, {63'd0, cout_o}, {63'd0, ec});
         check({name, "_ovf"},  {63'd0, ovf_o},  {63'd0, eo});
      end
      @(posedge clk_i);
      #1;
   endtask

   logic [W-1:0] st_a [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000,
                               32'h1234_5678, 32'h8000_0000, 32'h00FF_00FF, 32'hDEAD_BEEF};
   logic [W-1:0] st_b [8] = '{32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0001,
                               32'h1111_1111, 32'h0000_0001, 32'hFF00_FF00, 32'h0BAD_F00D};

   initial begin
      int stall_cnt;
      int out_base;
      int stray_valid;
      logic [3:0] idx;
      rst_i = 1'b1; in_valid_i = 1'b0; a_i = '0; b_i = '0;
      sub_i = 1'b0; cin_i = 1'b0; out_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
      check("rst_sum",       {32'd0, sum_o},       64'd0);
      check("rst_cout",      {63'd0, cout_o},      64'd0);
      check("rst_ovf",       {63'd0, ovf_o},       64'd0);
      check("rst_in_ready",  {63'd0, in_ready_o},  64'd1);
      @(posedge clk_i);
      #1;

      run_single("add_cross",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      run_single("ripple",     32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      run_single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_single("sub_pos",    32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
      run_single("sub_cin_ig", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
      run_single("add_mixed",  32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0);
      run_single("ovf_pos",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, E_OVF_POS,     1'b0, 1'b1);
      run_single("ovf_sub",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, E_OVF_SUB,     1'b1, 1'b1);
      run_single("ovf_neg",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, E_OVF_NEG,     1'b1, 1'b1);

      // Backpressure: 8 back-to-back ops, output stalled for 6 cycles mid-stream.
      out_base  = n_out;
      stall_cnt = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               bit acc;
               int guard;
               idx = 4'(i);
               a_i = st_a[i]; b_i = st_b[i]; sub_i = idx[0]; cin_i = idx[1];
               in_valid_i = 1'b1;
               acc   = 1'b0;
               guard = 0;
               while (!acc && guard < 30) begin
                  @(negedge clk_i);
                  acc = in_ready_o;
                  @(posedge clk_i);
                  #1;
                  guard++;
               end
               check("bp_accept_timeout", {63'd0, acc}, 64'd1);
            end
            in_valid_i = 1'b0;
         end
         begin
            repeat (6) @(posedge clk_i);
            #1 out_ready_i = 1'b0;
            repeat (6) @(posedge clk_i);
            #1 out_ready_i = 1'b1;
         end
         begin
            for (int c = 0; c < 20; c++) begin
               @(negedge clk_i);
               if (!in_ready_o) stall_cnt++;
            end
         end
      join
      repeat (10) @(posedge clk_i);
      #1;
      check("bp_stall_cycles", 64'(stall_cnt), 64'd6);
      check("bp_result_count", 64'(n_out - out_base), 64'd8);

      // Reset one cycle after the third accepted op: nothing may emerge.
      for (int i = 0; i < 3; i++) begin
         a_i = st_a[i]; b_i = st_b[i]; sub_i = 1'b0; cin_i = 1'b0; in_valid_i = 1'b1;
         @(posedge clk_i);
         #1;
      end
      in_valid_i = 1'b0;
      rst_i      = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      stray_valid = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         if (out_valid_o) stray_valid++;
      end
      check("rst_flush_no_out", 64'(stray_valid), 64'd0);
      @(posedge clk_i);
      #1;
      run_single("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      repeat (5) @(posedge clk_i);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
